// File: rtl/aclk_controller_if.sv
// Keypad/button/display bundle between the alarm-clock control FSM and its
// surroundings. master drives keys/buttons/tick, slave drives datapath controls.
interface aclk_controller_if;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       shift;
  logic       show_new_time;
  logic       show_a;
  logic       load_new_a;
  logic       load_new_c;
  logic [2:0] digit_count;

  modport master (
    output one_second,
    output key,
    output alarm_button,
    output time_button,
    input  shift,
    input  show_new_time,
    input  show_a,
    input  load_new_a,
    input  load_new_c,
    input  digit_count
  );

  modport slave (
    input  one_second,
    input  key,
    input  alarm_button,
    input  time_button,
    output shift,
    output show_new_time,
    output show_a,
    output load_new_a,
    output load_new_c,
    output digit_count
  );
endinterface

// File: rtl/aclk_controller.sv
// Alarm-clock control FSM: keypad entry, time/alarm load, alarm display, timeout.
// Ports: clk, reset (async, active-high), bus (slave: key/buttons/one_second in,
// shift/show_new_time/show_a/load_new_a/load_new_c/digit_count out).
module aclk_controller #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic              clk,
  input  logic              reset,
  aclk_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    SHOW_TIME,
    SHOW_ALARM,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_t;

  localparam logic [3:0] TO_MAX = 4'(TIMEOUT_SEC);
  localparam logic [2:0] DIG_MAX = 3'd4;
  localparam logic [3:0] NOKEY = 4'd10;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] tmo_q;
  logic [3:0] tmo_d;
  logic [2:0] dig_q;
  logic [2:0] dig_d;

  logic key_digit;
  logic key_none;
  logic timeout;
  logic full;

  // Codes 11..15 behave as NOKEY.
  assign key_digit = (bus.key < NOKEY);
  assign key_none  = !key_digit;
  assign timeout   = (tmo_q == TO_MAX);
  assign full      = (dig_q == DIG_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SHOW_TIME;
      tmo_q   <= 4'd0;
      dig_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      dig_q   <= dig_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    bus.shift         = 1'b0;
    bus.show_new_time = 1'b0;
    bus.show_a        = 1'b0;
    bus.load_new_a    = 1'b0;
    bus.load_new_c    = 1'b0;
    case (state_q)
      SHOW_TIME: begin
        if (bus.alarm_button) begin
          state_d = SHOW_ALARM;
        end else if (key_digit) begin
          state_d = KEY_STORED;
        end
      end
      SHOW_ALARM: begin
        bus.show_a = 1'b1;
        if (!bus.alarm_button) begin
          state_d = SHOW_TIME;
        end
      end
      KEY_STORED: begin
        bus.shift         = 1'b1;
        bus.show_new_time = 1'b1;
        state_d           = KEY_WAITED;
      end
      KEY_WAITED: begin
        bus.show_new_time = 1'b1;
        // Waiting for release, so a held key shifts only once.
        if (key_none) begin
          state_d = KEY_ENTRY;
        end else if (timeout) begin
          state_d = SHOW_TIME;
        end
      end
      KEY_ENTRY: begin
        bus.show_new_time = 1'b1;
        if (bus.alarm_button) begin
          state_d = full ? SET_ALARM_TIME : SHOW_TIME;
        end else if (bus.time_button) begin
          state_d = full ? SET_CURRENT_TIME : SHOW_TIME;
        end else if (key_digit) begin
          state_d = KEY_STORED;
        end else if (timeout) begin
          state_d = SHOW_TIME;
        end
      end
      SET_ALARM_TIME: begin
        bus.load_new_a = 1'b1;
        state_d        = SHOW_TIME;
      end
      SET_CURRENT_TIME: begin
        bus.load_new_c = 1'b1;
        state_d        = SHOW_TIME;
      end
      default: begin
        state_d = SHOW_TIME;
      end
    endcase
  end

  // Inactivity counter: restarts on every stored key, saturates at the limit.
  always_comb begin
    tmo_d = tmo_q;
    case (state_q)
      SHOW_TIME,
      KEY_STORED: begin
        tmo_d = 4'd0;
      end
      KEY_WAITED,
      KEY_ENTRY: begin
        if (bus.one_second && !timeout) begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      default: begin
        tmo_d = tmo_q;
      end
    endcase
  end

  // Digits entered this session; the datapath keeps only the last four.
  always_comb begin
    dig_d = dig_q;
    case (state_q)
      SHOW_TIME: begin
        dig_d = 3'd0;
      end
      KEY_STORED: begin
        if (!full) begin
          dig_d = dig_q + 3'd1;
        end
      end
      default: begin
        dig_d = dig_q;
      end
    endcase
  end

  assign bus.digit_count = dig_q;

endmodule
